// File: rtl/park_pkg.sv
// Shared types, default parameters and helpers for the parking gate controller.
package park_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OPEN_WAIT = 2'd1,
    PASSING   = 2'd2,
    CLOSING   = 2'd3
  } lane_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_OPEN_TIMEOUT    = 200;
  localparam int unsigned DEF_CLOSE_HOLD      = 16;

  // Timer must hold the larger of the two hold/timeout counts without wrapping.
  function automatic int unsigned timer_width(input int unsigned open_timeout,
                                              input int unsigned close_hold);
    int unsigned max_cnt;
    max_cnt = (open_timeout > close_hold) ? open_timeout : close_hold;
    return $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/park_gate_lane.sv
// One gate lane: sensor sync + debounce, barrier FSM with open/close timer,
// single-cycle pass pulse per vehicle.
module park_gate_lane
  import park_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned OPEN_TIMEOUT    = DEF_OPEN_TIMEOUT,
  parameter int unsigned CLOSE_HOLD      = DEF_CLOSE_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic req_raw,
  input  logic beam_raw,
  input  logic full_gate,
  output logic pass_pulse,
  output logic gate_open,
  output logic denied
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMR_W = timer_width(OPEN_TIMEOUT, CLOSE_HOLD);

  // Bit 0 = request, bit 1 = beam.
  logic [1:0]            sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  lane_state_e           state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d, timer_inc_c;
  logic                  gate_open_q, gate_open_d;
  logic                  pass_q, pass_d;
  logic                  denied_q, denied_d;
  logic                  req_rise_c, beam_fall_c, beam_lvl_c;

  // Synchronizer and run-length debouncer; level flips once the synced value
  // has disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    sync1_d = {beam_raw, req_raw};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // FSM reacts in the same cycle the debounced level flips.
  assign req_rise_c  = deb_d[0] & ~deb_q[0];
  assign beam_fall_c = ~deb_d[1] & deb_q[1];
  assign beam_lvl_c  = deb_d[1];
  assign timer_inc_c = (timer_q == {TMR_W{1'b1}}) ? timer_q : timer_q + TMR_W'(1);

  always_comb begin
    state_d  = state_q;
    pass_d   = 1'b0;
    denied_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_rise_c) begin
          if (full_gate) begin
            denied_d = 1'b1;
          end else begin
            state_d = OPEN_WAIT;
          end
        end
      end
      OPEN_WAIT: begin
        if (beam_lvl_c) begin
          state_d = PASSING;
        end else if (timer_inc_c >= TMR_W'(OPEN_TIMEOUT)) begin
          state_d = CLOSING;
        end
      end
      PASSING: begin
        if (beam_fall_c) begin
          pass_d  = 1'b1;
          state_d = CLOSING;
        end
      end
      CLOSING: begin
        if (timer_inc_c >= TMR_W'(CLOSE_HOLD)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Timer restarts on every state entry and only runs in timed states.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q == OPEN_WAIT || state_q == CLOSING) begin
      timer_d = timer_inc_c;
    end else begin
      timer_d = '0;
    end

    gate_open_d = (state_d == OPEN_WAIT) || (state_d == PASSING);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      timer_q     <= '0;
      gate_open_q <= 1'b0;
      pass_q      <= 1'b0;
      denied_q    <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      gate_open_q <= gate_open_d;
      pass_q      <= pass_d;
      denied_q    <= denied_d;
    end
  end

  assign pass_pulse = pass_q;
  assign gate_open  = gate_open_q;
  assign denied     = denied_q;

endmodule

// File: rtl/park_gate_ctrl.sv
// Entry/exit gate controller: two independent lanes feeding car_in/car_out
// pulses to the downstream parking counter.
module park_gate_ctrl
  import park_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned OPEN_TIMEOUT    = DEF_OPEN_TIMEOUT,
  parameter int unsigned CLOSE_HOLD      = DEF_CLOSE_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic entry_req,
  input  logic entry_beam,
  input  logic exit_req,
  input  logic exit_beam,
  input  logic parking_full,
  output logic car_in,
  output logic car_out,
  output logic entry_gate_open,
  output logic exit_gate_open,
  output logic entry_denied
);

  logic exit_denied_unused;

  park_gate_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .OPEN_TIMEOUT   (OPEN_TIMEOUT),
    .CLOSE_HOLD     (CLOSE_HOLD)
  ) u_entry_lane (
    .clk       (clk),
    .rst       (rst),
    .req_raw   (entry_req),
    .beam_raw  (entry_beam),
    .full_gate (parking_full),
    .pass_pulse(car_in),
    .gate_open (entry_gate_open),
    .denied    (entry_denied)
  );

  // Exits are never refused.
  park_gate_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .OPEN_TIMEOUT   (OPEN_TIMEOUT),
    .CLOSE_HOLD     (CLOSE_HOLD)
  ) u_exit_lane (
    .clk       (clk),
    .rst       (rst),
    .req_raw   (exit_req),
    .beam_raw  (exit_beam),
    .full_gate (1'b0),
    .pass_pulse(car_out),
    .gate_open (exit_gate_open),
    .denied    (exit_denied_unused)
  );

endmodule

// File: tb/tb_park_gate_ctrl.sv
// Scoreboard bench for park_gate_ctrl: stimulus queues expected event cycles,
// a negedge monitor pops and compares each observed pulse or gate transition.
module tb_park_gate_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic entry_req, entry_beam, exit_req, exit_beam, parking_full;
  logic car_in, car_out, entry_gate_open, exit_gate_open, entry_denied;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c;
  bit mon_en = 1'b0;
  logic eg_prev = 1'b0;
  logic xg_prev = 1'b0;

  int q_cin[$];
  int q_cout[$];
  int q_den[$];
  int q_eg[$];
  int q_xg[$];

  park_gate_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .entry_req      (entry_req),
    .entry_beam     (entry_beam),
    .exit_req       (exit_req),
    .exit_beam      (exit_beam),
    .parking_full   (parking_full),
    .car_in         (car_in),
    .car_out        (car_out),
    .entry_gate_open(entry_gate_open),
    .exit_gate_open (exit_gate_open),
    .entry_denied   (entry_denied)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic ev(input string nm, input int exp_cyc);
    total++;
    if (exp_cyc < 0) begin
      bad++;
      $display("FAIL %s: unexpected event at cycle %0d, none expected", nm, cyc);
    end else if (exp_cyc != cyc) begin
      bad++;
      $display("FAIL %s: event at cycle %0d, expected cycle %0d", nm, cyc, exp_cyc);
    end
  endtask

  task automatic chk(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b, expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_empty(input string nm, input int left);
    total++;
    if (left != 0) begin
      bad++;
      $display("FAIL %s: %0d expected events never seen, expected 0", nm, left);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_car_in"},  car_in,          1'b0);
    chk({tag, "_car_out"}, car_out,         1'b0);
    chk({tag, "_egate"},   entry_gate_open, 1'b0);
    chk({tag, "_xgate"},   exit_gate_open,  1'b0);
    chk({tag, "_denied"},  entry_denied,    1'b0);
  endtask

  // Monitor: every pulse and every gate edge must match the next queued cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (car_in)       ev("car_in",       (q_cin.size()  > 0) ? q_cin.pop_front()  : -1);
      if (car_out)      ev("car_out",      (q_cout.size() > 0) ? q_cout.pop_front() : -1);
      if (entry_denied) ev("entry_denied", (q_den.size()  > 0) ? q_den.pop_front()  : -1);
      if (entry_gate_open != eg_prev)
        ev("entry_gate_edge", (q_eg.size() > 0) ? q_eg.pop_front() : -1);
      if (exit_gate_open != xg_prev)
        ev("exit_gate_edge",  (q_xg.size() > 0) ? q_xg.pop_front() : -1);
      eg_prev = entry_gate_open;
      xg_prev = exit_gate_open;
    end
  end

  initial begin
    rst = 1'b0;
    entry_req = 1'b0; entry_beam = 1'b0;
    exit_req  = 1'b0; exit_beam  = 1'b0;
    parking_full = 1'b0;
    tick(3);
    chk_all_zero("reset");
    rst = 1'b1;
    mon_en = 1'b1;
    tick(3);

    // Normal entry; a request during the close hold is ignored.
    c = cyc; entry_req = 1'b1; q_eg.push_back(c + 6);
    tick(10); entry_req = 1'b0;
    tick(2);
    c = cyc; entry_beam = 1'b1;
    tick(20); entry_beam = 1'b0;
    q_cin.push_back(c + 26); q_eg.push_back(c + 26);
    tick(7); entry_req = 1'b1;
    tick(10); entry_req = 1'b0;
    tick(25);

    // Beam never breaks: gate times out after 200 cycles.
    c = cyc; entry_req = 1'b1;
    q_eg.push_back(c + 6); q_eg.push_back(c + 206);
    tick(8); entry_req = 1'b0;
    tick(230);

    // 3-cycle beam glitch ignored, then a minimal 4-cycle beam counts.
    c = cyc; entry_req = 1'b1; q_eg.push_back(c + 6);
    tick(8); entry_req = 1'b0;
    tick(4); entry_beam = 1'b1;
    tick(3); entry_beam = 1'b0;
    tick(10);
    chk("glitch_gate_up", entry_gate_open, 1'b1);
    c = cyc; entry_beam = 1'b1;
    tick(4); entry_beam = 1'b0;
    q_cin.push_back(c + 10); q_eg.push_back(c + 10);
    tick(30);

    // Lot full: entry denied, exit still served.
    parking_full = 1'b1;
    c = cyc; entry_req = 1'b1; exit_req = 1'b1;
    q_den.push_back(c + 6); q_xg.push_back(c + 6);
    tick(8); entry_req = 1'b0; exit_req = 1'b0;
    chk("full_egate_down", entry_gate_open, 1'b0);
    tick(2); exit_beam = 1'b1;
    tick(8); exit_beam = 1'b0;
    q_cout.push_back(c + 24); q_xg.push_back(c + 24);
    tick(8); parking_full = 1'b0;
    tick(25);

    // Both lanes clear in the same cycle; full asserted after admission is ignored.
    c = cyc; entry_req = 1'b1; exit_req = 1'b1;
    q_eg.push_back(c + 6); q_xg.push_back(c + 6);
    tick(8); entry_req = 1'b0; exit_req = 1'b0;
    tick(2); entry_beam = 1'b1; exit_beam = 1'b1;
    tick(2); parking_full = 1'b1;
    tick(8); entry_beam = 1'b0; exit_beam = 1'b0;
    q_cin.push_back(c + 26); q_cout.push_back(c + 26);
    q_eg.push_back(c + 26); q_xg.push_back(c + 26);
    tick(10); parking_full = 1'b0;
    tick(25);

    // Reset while PASSING: gate drops, no car_in; a fresh entry then works.
    c = cyc; entry_req = 1'b1; q_eg.push_back(c + 6);
    tick(8); entry_req = 1'b0;
    tick(2); entry_beam = 1'b1;
    tick(10); rst = 1'b0; q_eg.push_back(c + 21);
    tick(1);
    chk_all_zero("midreset");
    entry_beam = 1'b0;
    tick(2); rst = 1'b1;
    tick(10);
    c = cyc; entry_req = 1'b1; q_eg.push_back(c + 6);
    tick(8); entry_req = 1'b0;
    tick(2); entry_beam = 1'b1;
    tick(6); entry_beam = 1'b0;
    q_cin.push_back(c + 22); q_eg.push_back(c + 22);
    tick(30);

    chk_empty("car_in_pending",       q_cin.size());
    chk_empty("car_out_pending",      q_cout.size());
    chk_empty("entry_denied_pending", q_den.size());
    chk_empty("entry_gate_pending",   q_eg.size());
    chk_empty("exit_gate_pending",    q_xg.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
